// File: rtl/wsched_pkg.sv
// Constants and slot type shared by the wave issue scheduler and its execution
// responder, so both agree on the wave_scoreboard width and id encoding.
package wsched_pkg;
  localparam int W     = 8;
  localparam int IDW   = $clog2(W);
  localparam int DEPTH = 4;
  localparam int LW    = 4;
  localparam int SIW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW  = $clog2(DEPTH + 1);
  localparam int NID   = 1 << IDW;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
    logic [LW-1:0]  cnt;
  } slot_t;

  function automatic logic [W-1:0] onehot_id(input logic [IDW-1:0] id);
    return W'(1) << id;
  endfunction

  // Ids at or above W can only be encoded when W is not a power of two.
  function automatic logic [NID-1:0] id_in_range_mask();
    logic [NID-1:0] m;
    for (int i = 0; i < NID; i++) m[i] = (i < W);
    return m;
  endfunction
endpackage

// File: rtl/slot_prio_enc.sv
// Lowest-set-bit encoder over the slot table: index of the first request
// plus a flag telling whether any request is set.
module slot_prio_enc
  import wsched_pkg::*;
#(
  parameter int N  = DEPTH,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    // Walk downwards so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IW'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wave_exec_responder.sv
// Execution-side responder: holds accepted wave instructions in a small slot
// table, counts down their latency and retires one per cycle with retire_ack.
module wave_exec_responder
  import wsched_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [IDW-1:0]  issue_id,
  input  logic [LW-1:0]   issue_lat,
  input  logic            alu_stall,
  output logic            issue_accept,
  output logic            issue_reject,
  output logic            retire_ack,
  output logic [IDW-1:0]  retire_id,
  output logic [W-1:0]    wave_scoreboard,
  output logic [CNTW-1:0] inflight_cnt
);

  localparam logic [NID-1:0] ID_OK = id_in_range_mask();

  slot_t             slots_q [DEPTH];
  slot_t             slots_d [DEPTH];
  logic              retire_ack_q, retire_ack_d;
  logic [SIW-1:0]    ack_slot_q, ack_slot_d;
  logic [IDW-1:0]    retire_id_q, retire_id_d;
  logic [CNTW-1:0]   inflight_q, inflight_d;

  logic [DEPTH-1:0]  free_vec;
  logic [DEPTH-1:0]  ready_vec;
  logic [DEPTH-1:0]  done_req;
  logic [SIW-1:0]    free_idx, done_idx;
  logic              free_any, done_any;
  logic [W-1:0]      sb;
  logic [NID-1:0]    sb_ext;
  logic [LW-1:0]     lat_eff;
  logic              incoming_rdy;

  // A slot is retired in the cycle retire_ack shows it and freed at the end
  // of that cycle, so it stays in the scoreboard and is excluded from the
  // done candidates while being acknowledged.
  always_comb begin
    sb        = '0;
    free_vec  = '0;
    ready_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      free_vec[i] = !slots_q[i].valid;
      if (slots_q[i].valid) sb = sb | onehot_id(slots_q[i].id);
      ready_vec[i] = slots_q[i].valid && (slots_q[i].cnt <= LW'(1)) &&
                     !(retire_ack_q && (ack_slot_q == SIW'(i)));
    end
  end

  assign sb_ext          = NID'(sb);
  assign wave_scoreboard = sb;

  slot_prio_enc #(.N(DEPTH), .IW(SIW)) u_free_enc (
    .req_i (free_vec),
    .idx_o (free_idx),
    .any_o (free_any)
  );

  // Issue handshake: issue_valid presents one instruction for one cycle;
  // issue_accept means it was taken at the coming edge, issue_reject means it
  // was dropped and the scheduler must present it again later.
  assign issue_accept = issue_valid && !rst && !alu_stall && free_any &&
                        ID_OK[issue_id] && !sb_ext[issue_id];
  assign issue_reject = issue_valid && !rst && !issue_accept;

  assign lat_eff      = (issue_lat == '0) ? LW'(1) : issue_lat;
  // The accept cycle counts as the first execution cycle, so a latency-1
  // instruction competes for retirement on its own accept edge.
  assign incoming_rdy = issue_accept && (lat_eff == LW'(1));

  always_comb begin
    done_req = '0;
    for (int i = 0; i < DEPTH; i++) begin
      done_req[i] = ready_vec[i] || (incoming_rdy && (free_idx == SIW'(i)));
    end
  end

  slot_prio_enc #(.N(DEPTH), .IW(SIW)) u_done_enc (
    .req_i (done_req),
    .idx_o (done_idx),
    .any_o (done_any)
  );

  always_comb begin
    slots_d      = slots_q;
    retire_ack_d = 1'b0;
    ack_slot_d   = ack_slot_q;
    retire_id_d  = retire_id_q;
    inflight_d   = inflight_q + CNTW'(issue_accept) - CNTW'(retire_ack_q);
    if (retire_ack_q) slots_d[ack_slot_q].valid = 1'b0;
    if (!alu_stall) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (slots_q[i].valid && (slots_q[i].cnt != '0)) begin
          slots_d[i].cnt = slots_q[i].cnt - LW'(1);
        end
      end
      if (issue_accept) begin
        slots_d[free_idx].valid = 1'b1;
        slots_d[free_idx].id    = issue_id;
        slots_d[free_idx].cnt   = lat_eff - LW'(1);
      end
      if (done_any) begin
        retire_ack_d = 1'b1;
        ack_slot_d   = done_idx;
        retire_id_d  = (incoming_rdy && (free_idx == done_idx)) ? issue_id
                                                               : slots_q[done_idx].id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) slots_q[i] <= '0;
      retire_ack_q <= 1'b0;
      ack_slot_q   <= '0;
      retire_id_q  <= '0;
      inflight_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) slots_q[i] <= slots_d[i];
      retire_ack_q <= retire_ack_d;
      ack_slot_q   <= ack_slot_d;
      retire_id_q  <= retire_id_d;
      inflight_q   <= inflight_d;
    end
  end

  assign retire_ack   = retire_ack_q;
  assign retire_id    = retire_id_q;
  assign inflight_cnt = inflight_q;

endmodule

// File: tb/tb_wave_exec_responder.sv
// Bench for wave_exec_responder: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a latency-budget model.
module tb_wave_exec_responder;
  import wsched_pkg::*;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst;
  logic            issue_valid;
  logic [IDW-1:0]  issue_id;
  logic [LW-1:0]   issue_lat;
  logic            alu_stall;
  logic            issue_accept;
  logic            issue_reject;
  logic            retire_ack;
  logic [IDW-1:0]  retire_id;
  logic [W-1:0]    wave_scoreboard;
  logic [CNTW-1:0] inflight_cnt;

  always #5 clk = ~clk;

  wave_exec_responder dut (
    .clk             (clk),
    .rst             (rst),
    .issue_valid     (issue_valid),
    .issue_id        (issue_id),
    .issue_lat       (issue_lat),
    .alu_stall       (alu_stall),
    .issue_accept    (issue_accept),
    .issue_reject    (issue_reject),
    .retire_ack      (retire_ack),
    .retire_id       (retire_id),
    .wave_scoreboard (wave_scoreboard),
    .inflight_cnt    (inflight_cnt)
  );

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input int id, input int lat, input logic st, input logic r);
    issue_valid = v;
    issue_id    = IDW'(id);
    issue_lat   = LW'(lat);
    alu_stall   = st;
    rst         = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 0, 0, 1'b0, 1'b0);
      tick();
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Each instruction needs max(lat,1) non-stall cycles counting its accept
  // cycle; once its budget is spent it is eligible, the lowest slot among the
  // eligible ones is acknowledged next cycle and freed after that cycle.
  bit             m_v    [DEPTH];
  int             m_id   [DEPTH];
  int             m_need [DEPTH];
  int             m_run  [DEPTH];
  int             m_ack_slot = -1;
  logic [IDW-1:0] exp_q[$];
  bit             started = 1'b0;

  always @(negedge clk) begin
    logic [W-1:0]   e_sb;
    logic [IDW-1:0] e_id;
    int             occ;
    logic           e_acc;
    logic           e_rej;
    int             f;
    int             old;
    e_sb = '0;
    occ  = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_v[i]) begin
        e_sb = e_sb | (W'(1) << m_id[i]);
        occ++;
      end
    end
    e_acc = issue_valid && !rst && !alu_stall && (occ < DEPTH) && !e_sb[issue_id];
    e_rej = issue_valid && !rst && !e_acc;
    if (started) begin
      n_vec++;
      chk("accept", 32'(issue_accept), 32'(e_acc));
      chk("reject", 32'(issue_reject), 32'(e_rej));
      chk("scoreboard", 32'(wave_scoreboard), 32'(e_sb));
      chk("inflight", 32'(inflight_cnt), 32'(occ));
      if (exp_q.size() > 0) begin
        e_id = exp_q.pop_front();
        chk("retire_ack", 32'(retire_ack), 32'd1);
        chk("retire_id", 32'(retire_id), 32'(e_id));
      end else begin
        chk("retire_ack", 32'(retire_ack), 32'd0);
      end
    end
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
      m_ack_slot = -1;
      exp_q.delete();
      started = 1'b1;
    end else if (started) begin
      f = -1;
      for (int i = 0; i < DEPTH; i++) if (!m_v[i] && f < 0) f = i;
      old = m_ack_slot;
      m_ack_slot = -1;
      if (!alu_stall) begin
        for (int i = 0; i < DEPTH; i++) if (m_v[i] && i != old) m_run[i]++;
        if (e_acc) begin
          m_v[f]    = 1'b1;
          m_id[f]   = int'(issue_id);
          m_need[f] = (issue_lat == 0) ? 1 : int'(issue_lat);
          m_run[f]  = 1;
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (m_ack_slot < 0 && m_v[i] && i != old && m_run[i] >= m_need[i]) begin
            m_ack_slot = i;
            exp_q.push_back(IDW'(m_id[i]));
          end
        end
      end
      if (old >= 0) m_v[old] = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    tick();

    // Reset then idle.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 0, 0, 1'b0, 1'b0);
      #1;
      chk("idle_ack", 32'(retire_ack), 32'd0);
      chk("idle_sb", 32'(wave_scoreboard), 32'd0);
      chk("idle_cnt", 32'(inflight_cnt), 32'd0);
      tick();
    end

    // Single op: wave 3, latency 4.
    drive(1'b1, 3, 4, 1'b0, 1'b0);
    #1;
    chk("single_accept", 32'(issue_accept), 32'd1);
    tick();
    for (int k = 1; k <= 5; k++) begin
      drive(1'b0, 0, 0, 1'b0, 1'b0);
      #1;
      chk("single_sb", 32'(wave_scoreboard), (k <= 4) ? 32'h08 : 32'h00);
      chk("single_ack", 32'(retire_ack), (k == 4) ? 32'd1 : 32'd0);
      if (k == 4) chk("single_id", 32'(retire_id), 32'd3);
      tick();
    end
    idle(2);

    // Hazard on wave 2 (latency 6).
    drive(1'b1, 2, 6, 1'b0, 1'b0);
    #1;
    chk("haz_accept", 32'(issue_accept), 32'd1);
    tick();
    idle(2);
    drive(1'b1, 2, 1, 1'b0, 1'b0);
    #1;
    chk("haz_reject", 32'(issue_reject), 32'd1);
    tick();
    idle(2);
    drive(1'b1, 2, 1, 1'b0, 1'b0);
    #1;
    chk("haz_ret_ack", 32'(retire_ack), 32'd1);
    chk("haz_ret_id", 32'(retire_id), 32'd2);
    chk("haz_ret_reject", 32'(issue_reject), 32'd1);
    tick();
    drive(1'b1, 2, 1, 1'b0, 1'b0);
    #1;
    chk("haz_reaccept", 32'(issue_accept), 32'd1);
    tick();
    idle(4);

    // Full table with all four done together.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, k, 4 - k, 1'b0, 1'b0);
      #1;
      chk("full_accept", 32'(issue_accept), 32'd1);
      tick();
    end
    drive(1'b1, 5, 8, 1'b0, 1'b0);
    #1;
    chk("full_reject", 32'(issue_reject), 32'd1);
    chk("full_cnt", 32'(inflight_cnt), 32'd4);
    chk("full_ack0", 32'(retire_id), 32'd0);
    chk("full_ackv0", 32'(retire_ack), 32'd1);
    tick();
    drive(1'b1, 5, 8, 1'b0, 1'b0);
    #1;
    chk("full_cnt_after", 32'(inflight_cnt), 32'd3);
    chk("full_accept5", 32'(issue_accept), 32'd1);
    chk("full_ack1", 32'(retire_id), 32'd1);
    tick();
    for (int k = 2; k < 4; k++) begin
      drive(1'b0, 0, 0, 1'b0, 1'b0);
      #1;
      chk("full_ackv", 32'(retire_ack), 32'd1);
      chk("full_ack_id", 32'(retire_id), 32'(k));
      tick();
    end
    idle(12);

    // Stall: wave 4 latency 3, stalled for two cycles.
    drive(1'b1, 4, 3, 1'b0, 1'b0);
    #1;
    chk("stall_accept", 32'(issue_accept), 32'd1);
    tick();
    for (int k = 1; k <= 2; k++) begin
      drive(1'b1, 6, 2, 1'b1, 1'b0);
      #1;
      chk("stall_reject", 32'(issue_reject), 32'd1);
      tick();
    end
    for (int k = 3; k <= 5; k++) begin
      drive(1'b0, 0, 0, 1'b0, 1'b0);
      #1;
      chk("stall_ack", 32'(retire_ack), (k == 5) ? 32'd1 : 32'd0);
      if (k == 5) chk("stall_id", 32'(retire_id), 32'd4);
      tick();
    end
    idle(2);

    // Mid-flight reset.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, k, 9 + k, 1'b0, 1'b0);
      tick();
    end
    idle(1);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 7, 2, 1'b0, 1'b0);
    #1;
    chk("rst_sb", 32'(wave_scoreboard), 32'd0);
    chk("rst_cnt", 32'(inflight_cnt), 32'd0);
    chk("rst_accept", 32'(issue_accept), 32'd1);
    tick();
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    #1;
    chk("rst_ack_early", 32'(retire_ack), 32'd0);
    tick();
    #1;
    chk("rst_fresh_ack", 32'(retire_ack), 32'd1);
    chk("rst_fresh_id", 32'(retire_id), 32'd7);
    tick();
    for (int k = 0; k < 12; k++) begin
      drive(1'b0, 0, 0, 1'b0, 1'b0);
      #1;
      chk("rst_no_ack", 32'(retire_ack), 32'd0);
      tick();
    end

    // Randomized traffic.
    for (int c = 0; c < 2500; c++) begin
      drive($urandom_range(99) < 70, $urandom_range(W - 1), $urandom_range((1 << LW) - 1),
            $urandom_range(99) < 10, $urandom_range(299) == 0);
      tick();
    end
    idle(24);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
